// File: rtl/seg7_scan_driver_if.sv
// Display-driver bus: load port with shadow data/masks in, scanned segment/anode pins and status out.
// Latency: n/a (wiring only).
// Backpressure: none; load is a fire-and-forget strobe, pending reports commit status.
interface seg7_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   data;
    logic [DIGITS-1:0]     blank_mask;
    logic [DIGITS-1:0]     blink_mask;
    logic [6:0]            seg;
    logic [DIGITS-1:0]     an;
    logic                  pending;
    logic                  frame_tick;

    modport master (
        output load, data, blank_mask, blink_mask,
        input  seg, an, pending, frame_tick
    );

    modport slave (
        input  load, data, blank_mask, blink_mask,
        output seg, an, pending, frame_tick
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex display driver with per-digit blank/blink and frame-boundary commit.
// Latency: seg/an registered, 1 cycle behind the scan index; loads commit at the next frame_tick.
// Backpressure: none; a load before commit overwrites the shadow, pending shows it is waiting.
module seg7_scan_driver #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    seg7_scan_driver_if.slave  bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [6:0]        SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] AN_OFF  = ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    typedef enum logic {ST_RESET, ST_SCAN} state_t;

    typedef struct packed {
        logic [4*DIGITS-1:0] value;
        logic [DIGITS-1:0]   blank;
        logic [DIGITS-1:0]   blink;
    } disp_t;

    state_t            state;
    logic [PW-1:0]     presc;
    logic [IW-1:0]     idx;
    logic [FW-1:0]     frame_cnt;
    logic              blink_phase;
    disp_t             shadow;
    disp_t             shown;
    logic              pending_q;
    logic [6:0]        seg_q;
    logic [DIGITS-1:0] an_q;

    logic              presc_tc;
    logic              last_digit;
    logic              frame_tick_w;
    logic              commit;
    logic [3:0]        nib;
    logic              dark;
    logic [6:0]        seg_on;
    logic [DIGITS-1:0] an_hot;
    logic [6:0]        seg_nx;
    logic [DIGITS-1:0] an_nx;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign presc_tc     = (presc == PW'(SCAN_DIV - 1));
    assign last_digit   = (idx == IW'(DIGITS - 1));
    assign frame_tick_w = (state == ST_SCAN) && presc_tc && last_digit;
    assign commit       = frame_tick_w && pending_q;

    always_comb begin
        nib    = shown.value[{idx, 2'b00} +: 4];
        dark   = shown.blank[idx] | (shown.blink[idx] & blink_phase);
        seg_on = dark ? 7'h00 : decode(nib);
        an_hot = DIGITS'(1) << idx;
        seg_nx = ACTIVE_LOW ? ~seg_on : seg_on;
        an_nx  = ACTIVE_LOW ? ~an_hot : an_hot;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RESET;
            presc       <= '0;
            idx         <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            shadow      <= '0;
            shown       <= '0;
            pending_q   <= 1'b0;
            seg_q       <= SEG_OFF;
            an_q        <= AN_OFF;
        end else begin
            // A load coinciding with a commit keeps pending: the old shadow goes out, the new one waits.
            if (bus.load) begin
                shadow    <= '{value: bus.data, blank: bus.blank_mask, blink: bus.blink_mask};
                pending_q <= 1'b1;
            end else if (commit) begin
                pending_q <= 1'b0;
            end
            if (commit) begin
                shown <= shadow;
            end

            case (state)
                ST_RESET: begin
                    state <= ST_SCAN;
                    seg_q <= SEG_OFF;
                    an_q  <= AN_OFF;
                end
                ST_SCAN: begin
                    seg_q <= seg_nx;
                    an_q  <= an_nx;
                    if (presc_tc) begin
                        presc <= '0;
                        if (last_digit) begin
                            idx <= '0;
                            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                                frame_cnt   <= '0;
                                blink_phase <= ~blink_phase;
                            end else begin
                                frame_cnt <= frame_cnt + 1'b1;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                default: state <= ST_RESET;
            endcase
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.pending    = pending_q;
    assign bus.frame_tick = frame_tick_w;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2, active-low outputs.
// Each frame is walked cycle by cycle against hand-computed seg/an/pending/frame_tick values.
module tb_seg7_scan_driver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_driver_if #(.DIGITS(4)) bus ();

    seg7_scan_driver #(
        .DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_load(input logic en, input logic [15:0] d,
                              input logic [3:0] bl, input logic [3:0] bk);
        bus.load       = en;
        bus.data       = d;
        bus.blank_mask = bl;
        bus.blink_mask = bk;
    endtask

    // Called at the first cycle where digit 0 of a frame is visible; returns at the next frame's.
    // segs = {d3,d2,d1,d0} as active-low patterns; la/lb issue a load strobe in cycle j.
    task automatic check_frame(input string name, input logic [27:0] segs, input logic pend0,
                               input int la_j, input logic [15:0] la_d,
                               input logic [3:0] la_bl, input logic [3:0] la_bk,
                               input int lb_j, input logic [15:0] lb_d);
        for (int j = 0; j < 16; j++) begin
            int d;
            logic exp_pend;
            logic [3:0] exp_an;
            d = j / 4;
            exp_an = ~(4'b0001 << d);
            if (j < 15)
                exp_pend = pend0 || (la_j >= 0 && j > la_j) || (lb_j >= 0 && j > lb_j);
            else
                exp_pend = (la_j == 14) || (lb_j == 14);
            chk($sformatf("%s_an_j%0d", name, j), {28'd0, bus.an}, {28'd0, exp_an});
            chk($sformatf("%s_seg_j%0d", name, j), {25'd0, bus.seg}, {25'd0, segs[d*7 +: 7]});
            chk($sformatf("%s_tick_j%0d", name, j), {31'd0, bus.frame_tick}, {31'd0, (j == 14)});
            chk($sformatf("%s_pend_j%0d", name, j), {31'd0, bus.pending}, {31'd0, exp_pend});
            if (j == la_j)      drive_load(1'b1, la_d, la_bl, la_bk);
            else if (j == lb_j) drive_load(1'b1, lb_d, la_bl, la_bk);
            else                bus.load = 1'b0;
            step();
        end
        bus.load = 1'b0;
    endtask

    initial begin
        drive_load(1'b0, 16'h0000, 4'h0, 4'h0);
        rst = 1'b1;
        repeat (2) step();
        chk("rst_seg", {25'd0, bus.seg}, 32'h7F);
        chk("rst_an", {28'd0, bus.an}, 32'hF);
        chk("rst_pend", {31'd0, bus.pending}, 32'h0);
        chk("rst_tick", {31'd0, bus.frame_tick}, 32'h0);
        rst = 1'b0;
        step();
        chk("first_an_off", {28'd0, bus.an}, 32'hF);
        chk("first_seg_off", {25'd0, bus.seg}, 32'h7F);
        step();

        // idle zeros, then a mid-frame load of A5F0
        check_frame("idle", {7'h40, 7'h40, 7'h40, 7'h40}, 1'b0, -1, 16'h0, 4'h0, 4'h0, -1, 16'h0);
        check_frame("preA5", {7'h40, 7'h40, 7'h40, 7'h40}, 1'b0, 6, 16'hA5F0, 4'h0, 4'h0, -1, 16'h0);
        // A5F0 shown; two loads, latest (2222) wins
        check_frame("A5F0", {7'h08, 7'h12, 7'h0E, 7'h40}, 1'b0, 2, 16'h1111, 4'h0, 4'h0, 5, 16'h2222);
        // 2222 shown; load 4444 then a load of 3333 coincident with frame_tick
        check_frame("x2222", {7'h24, 7'h24, 7'h24, 7'h24}, 1'b0, 3, 16'h4444, 4'h0, 4'h0, 14, 16'h3333);
        check_frame("x4444", {7'h19, 7'h19, 7'h19, 7'h19}, 1'b1, -1, 16'h0, 4'h0, 4'h0, -1, 16'h0);
        // 3333 shown; load 8888 with digit1 blanked and digit3 blinking
        check_frame("x3333", {7'h30, 7'h30, 7'h30, 7'h30}, 1'b0, 4, 16'h8888, 4'b0010, 4'b1000, -1, 16'h0);
        check_frame("blk_off0", {7'h7F, 7'h00, 7'h7F, 7'h00}, 1'b0, -1, 16'h0, 4'h0, 4'h0, -1, 16'h0);
        check_frame("blk_off1", {7'h7F, 7'h00, 7'h7F, 7'h00}, 1'b0, -1, 16'h0, 4'h0, 4'h0, -1, 16'h0);
        check_frame("blk_on0", {7'h00, 7'h00, 7'h7F, 7'h00}, 1'b0, -1, 16'h0, 4'h0, 4'h0, -1, 16'h0);
        check_frame("blk_on1", {7'h00, 7'h00, 7'h7F, 7'h00}, 1'b0, -1, 16'h0, 4'h0, 4'h0, -1, 16'h0);

        // reset while a load is pending mid-scan
        drive_load(1'b1, 16'h9999, 4'h0, 4'h0);
        step();
        bus.load = 1'b0;
        chk("mid_pend", {31'd0, bus.pending}, 32'h1);
        chk("mid_an", {28'd0, bus.an}, 32'hE);
        step();
        rst = 1'b1;
        step();
        chk("rst2_an", {28'd0, bus.an}, 32'hF);
        chk("rst2_seg", {25'd0, bus.seg}, 32'h7F);
        chk("rst2_pend", {31'd0, bus.pending}, 32'h0);
        rst = 1'b0;
        step();
        chk("rst2_first_an", {28'd0, bus.an}, 32'hF);
        step();
        check_frame("post_rst", {7'h40, 7'h40, 7'h40, 7'h40}, 1'b0, -1, 16'h0, 4'h0, 4'h0, -1, 16'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed seven-segment display driver; successor to the single-digit 4-bit-to-segment decoder. It holds a DIGITS-wide hex value, scans one digit at a time through a shared segment bus, and supports per-digit blanking and blinking. Updates are tear-free: loaded data is committed to the display only at a frame boundary. It sits between the recognition core's result registers and the board's multiplexed display pins.

## Interface
- DIGITS, 4, number of digits scanned (1..8)
- SCAN_DIV, 50000, clocks each digit is held active (>=2)
- BLINK_FRAMES, 64, full scan frames per blink half-period (>=1)
- ACTIVE_LOW, 1, 1: seg and an are driven active-low; 0: active-high
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- load  in  1  one-cycle strobe; captures data, blank_mask and blink_mask into the shadow registers
- data  in  4*DIGITS  nibble i = value for digit i (digit 0 = rightmost)
- blank_mask  in  DIGITS  bit i = 1 forces digit i dark
- blink_mask  in  DIGITS  bit i = 1 makes digit i dark during blink-off phase
- seg  out  7  segments, bit0=a … bit6=g, polarity per ACTIVE_LOW
- an  out  DIGITS  one-hot digit enable, polarity per ACTIVE_LOW
- pending  out  1  high while shadow data is waiting for a frame commit
- frame_tick  out  1  one-cycle pulse when the last digit's hold period ends

## Operation
- Decode, internal active-high gfedcba: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Prescaler counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and the digit index advances. Index DIGITS-1 wraps to 0 and asserts frame_tick.
- Blink: a frame counter counts frame_ticks 0..BLINK_FRAMES-1. At wrap, blink_phase toggles. blink_phase=1 means off.
- Digit i is dark when blank_mask[i] | (blink_mask[i] & blink_phase) in the displayed registers. A dark digit outputs seg = all segments off, and its an stays asserted.
- Load handshake:
  - load copies the inputs into the shadow registers and sets pending.
  - On frame_tick with pending=1: displayed <= shadow, pending <= 0.
  - Repeated loads before the commit overwrite the shadow (latest wins).
  - load in the same cycle as a commit: the old shadow is committed, the new inputs are captured, and pending stays 1.
- Only one an bit is asserted at any time; no other combination is legal.
- States: RESET -> SCAN (index 0..DIGITS-1, cyclic). SCAN has no other exits; rst from any point returns to RESET.

## Timing
- Reset values:
  - seg = all off (7'h7F if ACTIVE_LOW else 7'h00); an = all off.
  - pending = 0, frame_tick = 0.
  - prescaler, index, frame counter and blink_phase = 0.
  - displayed and shadow value = 0; masks = 0.
- seg and an are registered and reflect the current index and displayed registers with 1-cycle latency. The first cycle after rst deasserts outputs are still off; from the second cycle, digit 0 shows 0.
- Each digit's an is asserted for exactly SCAN_DIV consecutive cycles. The frame period is DIGITS*SCAN_DIV cycles.
- frame_tick is combinationally tied to the terminal count of the last digit and is high for 1 cycle.
- Commit latency: from 1 cycle after load up to one full frame. The new digit pattern appears on seg 1 cycle after the commit.
- Blink half-period = BLINK_FRAMES*DIGITS*SCAN_DIV cycles.
- rst mid-frame or with pending=1 discards the shadow, drops pending and blanks outputs on the next edge.

## Test plan
Common parameters: DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2, ACTIVE_LOW=1.
- Reset then idle: after the first post-reset cycle, an cycles 1110→1101→1011→0111, 4 cycles each. seg=~3F (7'h40) on every digit. frame_tick every 16 cycles.
- load data=16'hA5F0 mid-frame: pending=1 until the next frame_tick, then 0. The next frame shows digit0=~3F, digit1=~71, digit2=~6D, digit3=~77. Digits are unchanged before the commit.
- Two loads (16'h1111, then 16'h2222) before one commit: only 2222 is displayed (seg=~5B). pending clears at that tick.
- load coincident with frame_tick: the previous shadow is displayed, pending remains 1, and the new value appears one frame later.
- blank_mask=4'b0010, blink_mask=4'b1000: digit1 is always 7'h7F. Digit3 alternates shown/dark every 2 frames (32 cycles). an timing is unaffected.
- Assert rst while pending=1 mid-scan: the next cycle shows an=4'hF, seg=7'h7F, pending=0. The display resumes with zeros.
